// File: rtl/piano_pkg.sv
// Shared piano definitions: PS/2 prefix codes, note type and the scan-code-to-note key map.
package piano_pkg;

    localparam int unsigned NOTE_W     = 4;
    localparam logic [7:0]  BREAK_CODE = 8'hF0;
    localparam logic [7:0]  EXT_CODE   = 8'hE0;

    typedef logic [NOTE_W-1:0] note_t;

    typedef struct packed {
        logic  hit;
        note_t note;
    } key_lookup_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } dec_state_t;

    function automatic key_lookup_t scan_to_note(input logic [7:0] code);
        key_lookup_t r;
        r.hit  = 1'b1;
        r.note = '0;
        case (code)
            8'h1C: r.note = NOTE_W'(0);
            8'h1D: r.note = NOTE_W'(1);
            8'h1B: r.note = NOTE_W'(2);
            8'h24: r.note = NOTE_W'(3);
            8'h23: r.note = NOTE_W'(4);
            8'h2B: r.note = NOTE_W'(5);
            8'h2C: r.note = NOTE_W'(6);
            8'h34: r.note = NOTE_W'(7);
            8'h35: r.note = NOTE_W'(8);
            8'h33: r.note = NOTE_W'(9);
            8'h3C: r.note = NOTE_W'(10);
            8'h3B: r.note = NOTE_W'(11);
            8'h42: r.note = NOTE_W'(12);
            default: r.hit = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/voice_allocator_if.sv
// Scan-byte input and voice-table output bundle between the PS/2 side and the tone generators.
interface voice_allocator_if #(
    parameter int unsigned NUM_VOICES = 4
);
    import piano_pkg::*;

    logic [7:0]                   scan_code;
    logic                         scan_valid;
    logic [NUM_VOICES-1:0]        voice_active;
    logic [NUM_VOICES*NOTE_W-1:0] voice_note;
    logic                         steal;

    modport master (
        output scan_code, scan_valid,
        input  voice_active, voice_note, steal
    );

    modport slave (
        input  scan_code, scan_valid,
        output voice_active, voice_note, steal
    );
endinterface

// File: rtl/voice_allocator_key_event_decoder.sv
// PS/2 make/break sequence decoder; emits same-cycle press/release pulses for mapped keys.
module key_event_decoder
    import piano_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_scan_code,
    input  logic       i_scan_valid,
    output logic       o_press_c,
    output logic       o_release_c,
    output note_t      o_note_c
);

    dec_state_t  r_state;
    dec_state_t  w_state_nxt;
    key_lookup_t w_lookup;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Extended sequences are consumed but never produce note events.
    always_comb begin
        w_state_nxt = r_state;
        o_press_c   = 1'b0;
        o_release_c = 1'b0;
        w_lookup    = scan_to_note(i_scan_code);
        o_note_c    = w_lookup.note;
        if (i_scan_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (i_scan_code == BREAK_CODE)    w_state_nxt = ST_BRK;
                    else if (i_scan_code == EXT_CODE) w_state_nxt = ST_EXT;
                    else                              o_press_c   = w_lookup.hit;
                end
                ST_BRK: begin
                    o_release_c = w_lookup.hit;
                    w_state_nxt = ST_IDLE;
                end
                ST_EXT:     w_state_nxt = (i_scan_code == BREAK_CODE) ? ST_EXT_BRK : ST_IDLE;
                ST_EXT_BRK: w_state_nxt = ST_IDLE;
                default:    w_state_nxt = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps held notes onto voices, stealing the oldest voice when full.
module voice_allocator
    import piano_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 4
) (
    input  logic             sys_clk,
    input  logic             async_rst,
    voice_allocator_if.slave bus
);

    localparam int unsigned AGE_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    typedef logic [AGE_W-1:0] age_t;

    logic                  w_press;
    logic                  w_release;
    note_t                 w_note;

    logic [NUM_VOICES-1:0] r_active;
    note_t                 r_note [NUM_VOICES];
    age_t                  r_age  [NUM_VOICES];
    logic                  r_steal;

    logic [NUM_VOICES-1:0] w_active_nxt;
    note_t                 w_note_nxt [NUM_VOICES];
    age_t                  w_age_nxt  [NUM_VOICES];
    logic                  w_steal_nxt;

    logic                  w_hit_found;
    age_t                  w_hit_idx;
    logic                  w_free_found;
    age_t                  w_free_idx;
    age_t                  w_old_idx;
    age_t                  w_old_age;
    age_t                  w_tgt_idx;
    age_t                  w_tgt_thr;

    key_event_decoder u_dec (
        .i_clk        (sys_clk),
        .i_rst        (async_rst),
        .i_scan_code  (bus.scan_code),
        .i_scan_valid (bus.scan_valid),
        .o_press_c    (w_press),
        .o_release_c  (w_release),
        .o_note_c     (w_note)
    );

    // Voice searches: holder of the note, lowest free voice, oldest voice (ties to lowest index).
    always_comb begin
        w_hit_found  = 1'b0;
        w_hit_idx    = '0;
        w_free_found = 1'b0;
        w_free_idx   = '0;
        w_old_idx    = '0;
        w_old_age    = r_age[0];
        for (int v = 0; v < int'(NUM_VOICES); v++) begin
            if (!w_hit_found && r_active[v] && (r_note[v] == w_note)) begin
                w_hit_found = 1'b1;
                w_hit_idx   = AGE_W'(v);
            end
            if (!w_free_found && !r_active[v]) begin
                w_free_found = 1'b1;
                w_free_idx   = AGE_W'(v);
            end
            if (r_age[v] > w_old_age) begin
                w_old_age = r_age[v];
                w_old_idx = AGE_W'(v);
            end
        end
    end

    // Next voice table; ages stay a strict recency ordering among active voices.
    always_comb begin
        w_active_nxt = r_active;
        w_note_nxt   = r_note;
        w_age_nxt    = r_age;
        w_steal_nxt  = 1'b0;
        w_tgt_idx    = w_free_found ? w_free_idx : w_old_idx;
        w_tgt_thr    = w_free_found ? AGE_W'(NUM_VOICES - 1) : w_old_age;
        if (w_press && !w_hit_found) begin
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                if (r_active[v] && (AGE_W'(v) != w_tgt_idx) && (r_age[v] < w_tgt_thr))
                    w_age_nxt[v] = r_age[v] + AGE_W'(1);
            end
            w_active_nxt[w_tgt_idx] = 1'b1;
            w_note_nxt[w_tgt_idx]   = w_note;
            w_age_nxt[w_tgt_idx]    = '0;
            w_steal_nxt             = !w_free_found;
        end else if (w_release && w_hit_found) begin
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                if (r_active[v] && (AGE_W'(v) != w_hit_idx) && (r_age[v] > r_age[w_hit_idx]))
                    w_age_nxt[v] = r_age[v] - AGE_W'(1);
            end
            w_active_nxt[w_hit_idx] = 1'b0;
            w_note_nxt[w_hit_idx]   = '0;
            w_age_nxt[w_hit_idx]    = '0;
        end
    end

    always_ff @(posedge sys_clk or posedge async_rst) begin
        if (async_rst) begin
            r_active <= '0;
            r_steal  <= 1'b0;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                r_note[v] <= '0;
                r_age[v]  <= '0;
            end
        end else begin
            r_active <= w_active_nxt;
            r_steal  <= w_steal_nxt;
            for (int v = 0; v < int'(NUM_VOICES); v++) begin
                r_note[v] <= w_note_nxt[v];
                r_age[v]  <= w_age_nxt[v];
            end
        end
    end

    assign bus.voice_active = r_active;
    assign bus.steal        = r_steal;

    for (genvar g = 0; g < int'(NUM_VOICES); g++) begin : g_note_out
        assign bus.voice_note[g*NOTE_W +: NOTE_W] = r_note[g];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed plus randomized check of voice_allocator against an allocation-order reference model.
module tb_voice_allocator;

    localparam int NV = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    voice_allocator_if #(.NUM_VOICES(NV)) bus ();

    voice_allocator #(.NUM_VOICES(NV)) dut (
        .sys_clk   (clk),
        .async_rst (rst),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: voices plus a recency queue (front = oldest allocated voice).
    bit         m_act  [NV];
    int         m_note [NV];
    int         m_q    [$];
    bit         m_steal;
    bit         m_brk;
    bit         m_ext;
    bit         m_ext_brk;
    logic [7:0] keymap [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                               8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};

    function automatic int key_note(input logic [7:0] b);
        for (int k = 0; k < 13; k++) if (keymap[k] == b) return k;
        return -1;
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_act[v]  = 1'b0;
            m_note[v] = 0;
        end
        m_q.delete();
        m_steal   = 1'b0;
        m_brk     = 1'b0;
        m_ext     = 1'b0;
        m_ext_brk = 1'b0;
    endfunction

    function automatic void model_press(input int n);
        int v;
        for (int i = 0; i < NV; i++) if (m_act[i] && m_note[i] == n) return;
        for (int i = 0; i < NV; i++) begin
            if (!m_act[i]) begin
                m_act[i]  = 1'b1;
                m_note[i] = n;
                m_q.push_back(i);
                return;
            end
        end
        v = m_q.pop_front();
        m_note[v] = n;
        m_q.push_back(v);
        m_steal = 1'b1;
    endfunction

    function automatic void model_release(input int n);
        for (int i = 0; i < NV; i++) begin
            if (m_act[i] && m_note[i] == n) begin
                m_act[i]  = 1'b0;
                m_note[i] = 0;
                for (int j = 0; j < m_q.size(); j++) begin
                    if (m_q[j] == i) begin
                        m_q.delete(j);
                        break;
                    end
                end
                return;
            end
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int n;
        n = key_note(b);
        m_steal = 1'b0;
        if (m_ext_brk) begin
            m_ext_brk = 1'b0;
        end else if (m_ext) begin
            m_ext     = 1'b0;
            m_ext_brk = (b == 8'hF0);
        end else if (m_brk) begin
            m_brk = 1'b0;
            if (n >= 0) model_release(n);
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (n >= 0) begin
            model_press(n);
        end
    endfunction

    function automatic logic [NV-1:0] exp_active();
        logic [NV-1:0] r;
        for (int v = 0; v < NV; v++) r[v] = m_act[v];
        return r;
    endfunction

    function automatic logic [NV*4-1:0] exp_notes();
        logic [NV*4-1:0] r;
        for (int v = 0; v < NV; v++) r[v*4 +: 4] = m_act[v] ? 4'(m_note[v]) : 4'd0;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".active"}, 32'(bus.voice_active), 32'(exp_active()));
        check({tag, ".note"},   32'(bus.voice_note),   32'(exp_notes()));
        check({tag, ".steal"},  32'(bus.steal),        32'(m_steal));
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        bus.scan_code  = b;
        bus.scan_valid = 1'b1;
        model_byte(b);
        @(posedge clk);
        #1;
        bus.scan_valid = 1'b0;
        check_model($sformatf("byte_%h", b));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check_model("reset");
    endtask

    initial begin
        logic [7:0] pool [8] = '{8'hF0, 8'hF0, 8'hE0, 8'h5A, 8'h75, 8'h1C, 8'h42, 8'h2C};
        logic [7:0] b;
        bus.scan_code  = '0;
        bus.scan_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();

        // Ignored input: extended sequences, unmapped make, break of unheld note.
        send(8'hE0); send(8'h75);
        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'h5A);
        send(8'hF0); send(8'h3B);
        check("ignored.all_zero", 32'(bus.voice_active), 32'd0);

        do_reset();
        send(8'h1C); send(8'h1B);
        check("basic.active", 32'(bus.voice_active), 32'b0011);
        check("basic.note", 32'(bus.voice_note), 32'h0020);

        do_reset();
        repeat (5) send(8'h1C);
        check("typematic.held", 32'(bus.voice_active), 32'b0001);
        send(8'hF0); send(8'h1C);
        check("typematic.freed", 32'(bus.voice_active), 32'b0000);

        do_reset();
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B);
        send(8'h34);
        check("overflow.steal", 32'(bus.steal), 32'd1);
        send(8'h33);
        check("overflow.steal_again", 32'(bus.steal), 32'd1);
        check("overflow.note", 32'(bus.voice_note), 32'h5497);

        do_reset();
        send(8'h1C); send(8'h1B); send(8'h23);
        send(8'hF0); send(8'h1B);
        check("ooo.freed", 32'(bus.voice_active), 32'b0101);
        send(8'h42);
        send(8'h2B);
        send(8'h2C);
        check("ooo.steal", 32'(bus.steal), 32'd1);
        check("ooo.note", 32'(bus.voice_note), 32'h54C6);

        // Reset between break prefix and key byte.
        do_reset();
        send(8'hF0);
        do_reset();
        send(8'h1C);
        check("midbrk.active", 32'(bus.voice_active), 32'b0001);

        // Randomized byte stream, back to back.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 1) == 0) b = keymap[$urandom_range(0, 12)];
            else                           b = pool[$urandom_range(0, 7)];
            send(b);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic voice allocator between the `ps2_receiver` byte stream and the tone generators. It decodes PS/2 make/break sequences into note press/release events and assigns each held note to one of `NUM_VOICES` tone-generator voices. When all voices are busy, it steals the oldest voice. Typematic repeats of a held key are absorbed, so a held note stays on exactly one voice.

## Interface
- `NUM_VOICES`, 4: number of tone-generator voices, 2..8.
- `NOTE_W`, 4: note index width; notes 0..12 = C4..C5.

- `sys_clk`  in  1: system clock.
- `async_rst`  in  1: asynchronous, active-high reset.
- `scan_code`  in  8: received PS/2 byte.
- `scan_valid`  in  1: one-cycle strobe; `scan_code` valid this cycle. At most one byte per cycle.
- `voice_active`  out  NUM_VOICES: bit v = voice v is sounding.
- `voice_note`  out  NUM_VOICES*NOTE_W: voice v note in bits [v*NOTE_W +: NOTE_W].
- `steal`  out  1: one-cycle pulse when a press evicted an active voice.

## Operation
- Decoder FSM, advancing only on `scan_valid`:
  - IDLE: 0xF0 goes to BRK; 0xE0 goes to EXT; any other byte is a make code and stays in IDLE.
  - BRK: any byte is a break code; return to IDLE.
  - EXT: 0xF0 goes to EXT_BRK; any other byte is ignored; return to IDLE.
  - EXT_BRK: any byte is ignored; return to IDLE.
- Key map, fixed:
  - 1C=0, 1D=1, 1B=2, 24=3, 23=4, 2B=5, 2C=6, 34=7, 35=8, 33=9, 3C=10, 3B=11, 42=12.
  - Unmapped codes produce no event.
- Press of note n:
  - n already on a voice: no change; this covers typematic repeats.
  - Otherwise, if a voice is free: the lowest-index free voice takes n.
  - Otherwise: steal the oldest voice (maximum age; ties go to the lowest index), load n, pulse `steal`.
- Age tracking:
  - One `$clog2(NUM_VOICES)`-bit age per voice.
  - On allocation or steal, the target voice's age becomes 0.
  - Every other active voice whose age is below the target's old age (or below NUM_VOICES-1 for a free target) increments.
  - Ages stay a strict ordering of active voices.
- Release of note n:
  - The voice holding n clears `voice_active`, its `voice_note` becomes 0, and its age becomes 0.
  - Active voices older than the released voice decrement their age.
  - Release of a note not held is ignored.
- Free voices always read `voice_note`=0.

## Timing
- Outputs are registered. The voice update and `steal` appear on the first `sys_clk` edge after the `scan_valid` cycle carrying the final byte of a sequence.
- Prefix bytes (F0/E0) never change outputs.
- Throughput: back-to-back `scan_valid` strobes every cycle are accepted.
- Reset value of all outputs is 0, FSM is IDLE, all ages are 0.
- Reset mid-sequence (after F0, before the key byte) discards the prefix. The next byte is decoded from IDLE as a make code.
- `steal` is never high two consecutive cycles unless two consecutive evicting presses occur.

## Structure
- Shared `piano_pkg`:
  - `BREAK_CODE`=8'hF0 and `EXT_CODE`=8'hE0.
  - `NOTE_W` and the note-index typedef.
  - Function `scan_to_note(code)` returning {hit, note}; also used by the tone generators and benches.
- Sub-module `key_event_decoder`:
  - Contains the 4-state FSM plus the `scan_to_note` lookup.
  - Emits one-cycle `press`/`release` pulses with `note`.
- `voice_allocator` top holds the voice table, ages, hit/free/oldest search, and output registers.

## Test plan
- After reset: press 1C and 1B -> voice0=0, voice1=2 active; `voice_active`=0011.
- Typematic hold: 1C five times, then F0 1C -> voice0 stays note 0 with no other voice touched, then voice0 frees; `voice_active`=0000.
- Overflow: press 1C, 1B, 23, 2B, then 34 -> `steal` pulses once and voice0 gets note 7; then press 33 -> voice1 gets note 9.
- Out-of-order release:
  - Press 1C, 1B, 23, then F0 1B -> voice1 frees.
  - Press 42 -> voice1 gets note 12 (lowest free).
  - Then fill all voices and press 2C -> voice0 (oldest) is stolen.
- Ignored input: E0 75, E0 F0 75, press 0x5A, F0 0x3B (not held) -> outputs unchanged from all-zero.
- Reset mid-break: F0, async_rst pulse, then 1C -> voice0=0 active (treated as make).
